// File: rtl/tile_cursor_pkg.sv
// Shared definitions for the LCD tile cursor controller.
//   - cfg_mode_e : host configuration opcodes carried on in_cfg_mode
//   - run_state_e: cursor run/stop state
//   - DEF_*      : default panel geometry (480x272 panel, 8x8 tiles)
package tile_cursor_pkg;

    localparam int DEF_COLS       = 60;
    localparam int DEF_ROWS       = 34;
    localparam int DEF_TILE_SHIFT = 3;

    typedef enum logic [1:0] {
        MODE_STOP = 2'd0,
        MODE_RUN  = 2'd1,
        MODE_JUMP = 2'd2,
        MODE_HOME = 2'd3
    } cfg_mode_e;

    typedef enum logic {
        S_STOP = 1'b0,
        S_RUN  = 1'b1
    } run_state_e;

endpackage

// File: rtl/tile_pos_step.sv
// Registered cursor position with home, load and step.
// Ports:
//   clk, rst             : clock and synchronous active-high reset
//   home                 : force position to (0,0)        (highest priority)
//   load, load_x, load_y : load an already-clamped position
//   step                 : advance raster-order by one tile
//   tile_x, tile_y       : current position
//   step_pulse           : one-cycle pulse after each step
//   wrap_pulse           : one-cycle pulse after the last-tile -> (0,0) step
module tile_pos_step import tile_cursor_pkg::*; #(
    parameter int COLS = DEF_COLS,
    parameter int ROWS = DEF_ROWS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       home,
    input  logic       load,
    input  logic [6:0] load_x,
    input  logic [5:0] load_y,
    input  logic       step,
    output logic [6:0] tile_x,
    output logic [5:0] tile_y,
    output logic       step_pulse,
    output logic       wrap_pulse
);

    localparam logic [6:0] X_MAX = 7'(COLS - 1);
    localparam logic [5:0] Y_MAX = 6'(ROWS - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            tile_x     <= '0;
            tile_y     <= '0;
            step_pulse <= 1'b0;
            wrap_pulse <= 1'b0;
        end else begin
            step_pulse <= 1'b0;
            wrap_pulse <= 1'b0;
            if (home) begin
                tile_x <= '0;
                tile_y <= '0;
            end else if (load) begin
                tile_x <= load_x;
                tile_y <= load_y;
            end else if (step) begin
                step_pulse <= 1'b1;
                if (tile_x < X_MAX) begin
                    tile_x <= tile_x + 7'd1;
                end else begin
                    tile_x <= '0;
                    if (tile_y < Y_MAX) begin
                        tile_y <= tile_y + 6'd1;
                    end else begin
                        tile_y     <= '0;
                        wrap_pulse <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/lcd_tile_cursor_ctrl.sv
// Frame-synchronous 8x8 tile cursor controller for the 480x272 LCD.
// Host requests are captured into a shadow register through a valid/ready
// handshake and only applied at the next frame start, so the cursor never
// moves mid-frame.
// Ports:
//   in_clk, in_rst                 : pixel clock, synchronous active-high reset
//   in_frame_start                 : one-cycle frame-start pulse
//   in_pixelx, in_pixely           : current pixel coordinate
//   in_cfg_valid / out_cfg_ready   : configuration handshake
//   in_cfg_mode/x/y/div            : configuration request fields
//   out_tile_x, out_tile_y         : cursor tile position
//   out_hit                        : previous-cycle pixel lies in the cursor tile
//   out_step, out_wrap             : advance / wrap-around pulses
module lcd_tile_cursor_ctrl import tile_cursor_pkg::*; #(
    parameter int COLS       = DEF_COLS,
    parameter int ROWS       = DEF_ROWS,
    parameter int TILE_SHIFT = DEF_TILE_SHIFT,
    parameter int DIV_W      = 8
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             in_frame_start,
    input  logic [9:0]       in_pixelx,
    input  logic [9:0]       in_pixely,
    input  logic             in_cfg_valid,
    output logic             out_cfg_ready,
    input  logic [1:0]       in_cfg_mode,
    input  logic [6:0]       in_cfg_x,
    input  logic [5:0]       in_cfg_y,
    input  logic [DIV_W-1:0] in_cfg_div,
    output logic [6:0]       out_tile_x,
    output logic [5:0]       out_tile_y,
    output logic             out_hit,
    output logic             out_step,
    output logic             out_wrap
);

    localparam logic [6:0] X_MAX = 7'(COLS - 1);
    localparam logic [5:0] Y_MAX = 6'(ROWS - 1);

    function automatic logic [6:0] clamp_x(input logic [6:0] x);
        return (x > X_MAX) ? X_MAX : x;
    endfunction

    function automatic logic [5:0] clamp_y(input logic [5:0] y);
        return (y > Y_MAX) ? Y_MAX : y;
    endfunction

    run_state_e       state, state_nxt;
    logic             pending;
    cfg_mode_e        sh_mode;
    logic [6:0]       sh_x;
    logic [5:0]       sh_y;
    logic [DIV_W-1:0] sh_div;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] fcnt;

    logic accept;
    logic apply;
    logic pos_home;
    logic pos_load;
    logic pos_step;
    logic hit_p0;

    // Ready is forced low during reset so nothing is accepted while held.
    assign out_cfg_ready = ~pending & ~in_rst;
    assign accept        = in_cfg_valid & out_cfg_ready;
    assign apply         = in_frame_start & pending;

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state <= S_STOP;
        end else begin
            state <= state_nxt;
        end
    end

    // A pending config pre-empts stepping for the frame it is applied in.
    always_comb begin
        state_nxt = state;
        pos_home  = 1'b0;
        pos_load  = 1'b0;
        pos_step  = 1'b0;
        if (apply) begin
            if (sh_mode == MODE_STOP) state_nxt = S_STOP;
            if (sh_mode == MODE_RUN)  state_nxt = S_RUN;
            if (sh_mode == MODE_HOME) begin
                state_nxt = S_STOP;
                pos_home  = 1'b1;
            end
            if (sh_mode == MODE_JUMP) pos_load = 1'b1;
        end else if (in_frame_start && state == S_RUN && fcnt == div) begin
            pos_step = 1'b1;
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            pending <= 1'b0;
            div     <= '0;
            fcnt    <= '0;
        end else begin
            if (apply) begin
                pending <= 1'b0;
            end else if (accept) begin
                pending <= 1'b1;
            end

            if (apply && sh_mode == MODE_RUN) begin
                div <= sh_div;
            end

            if (apply || state == S_STOP || pos_step) begin
                fcnt <= '0;
            end else if (in_frame_start) begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    // Shadow fields are only meaningful while pending is set.
    always_ff @(posedge in_clk) begin
        if (accept) begin
            sh_mode <= cfg_mode_e'(in_cfg_mode);
            sh_x    <= in_cfg_x;
            sh_y    <= in_cfg_y;
            sh_div  <= in_cfg_div;
        end
    end

    tile_pos_step #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_pos (
        .clk        (in_clk),
        .rst        (in_rst),
        .home       (pos_home),
        .load       (pos_load),
        .load_x     (clamp_x(sh_x)),
        .load_y     (clamp_y(sh_y)),
        .step       (pos_step),
        .tile_x     (out_tile_x),
        .tile_y     (out_tile_y),
        .step_pulse (out_step),
        .wrap_pulse (out_wrap)
    );

    // Stage p0: tile-coordinate compare against the current position
    assign hit_p0 = ((in_pixelx >> TILE_SHIFT) == 10'(out_tile_x)) &&
                    ((in_pixely >> TILE_SHIFT) == 10'(out_tile_y));

    // Stage p1: registered hit
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            out_hit <= 1'b0;
        end else begin
            out_hit <= hit_p0;
        end
    end

endmodule

// File: doc/lcd_tile_cursor_ctrl.md
# lcd_tile_cursor_ctrl

Frame-synchronous controller for the 8×8 tile cursor on the 480×272 LCD panel (60×34 tiles). Holds cursor position and run/stop state, advances the cursor on frame boundaries at a configurable rate, and accepts host configuration through a valid/ready handshake. Changes are applied only at frame start, so the cursor never tears mid-frame. It sits between the LCD timing generator (frame pulse, pixel coordinates) and the pixel colour mux, which consumes `out_hit`.

## Interface
- `COLS`, 60: tile columns; positions 0..COLS-1.
- `ROWS`, 34: tile rows; positions 0..ROWS-1.
- `TILE_SHIFT`, 3: log2 of tile size in pixels.
- `DIV_W`, 8: width of the frame divider.

- `in_clk`  in  1: pixel clock (9 MHz domain). Single clock.
- `in_rst`  in  1: reset, synchronous, active-high.
- `in_frame_start`  in  1: one-cycle pulse at frame start, already synchronous to `in_clk`.
- `in_pixelx`  in  10: current pixel column.
- `in_pixely`  in  10: current pixel row.
- `in_cfg_valid`  in  1: configuration request.
- `out_cfg_ready`  out  1: request can be accepted.
- `in_cfg_mode`  in  2: 0 STOP, 1 RUN, 2 JUMP, 3 HOME.
- `in_cfg_x`  in  7: JUMP column.
- `in_cfg_y`  in  6: JUMP row.
- `in_cfg_div`  in  DIV_W: RUN rate; step every div+1 frames.
- `out_tile_x`  out  7: cursor column.
- `out_tile_y`  out  6: cursor row.
- `out_hit`  out  1: pixel at the previous cycle lies inside the cursor tile.
- `out_step`  out  1: one-cycle pulse when the cursor advances.
- `out_wrap`  out  1: one-cycle pulse on the (COLS-1,ROWS-1)→(0,0) advance.

## Operation
- Run states: `S_STOP` and `S_RUN`. Registers: position, divider `div`, frame counter `fcnt`, shadow config, `pending` flag.
- Handshake: `out_cfg_ready` = ~pending. A request is accepted when valid & ready; the fields go to shadow and `pending` is set. While `pending` is set, valid is ignored and the host holds the request.
- At `in_frame_start`, when `pending` is set, the shadow is applied, `pending` clears, `fcnt` is set to 0, and no step occurs this frame.
  - STOP → `S_STOP`; position held.
  - RUN → `div` = `in_cfg_div`, `S_RUN`; position held.
  - JUMP → position = (min(x,COLS-1), min(y,ROWS-1)); state and `div` unchanged.
  - HOME → position (0,0), `S_STOP`.
- At `in_frame_start` with no pending config in `S_RUN`:
  - If `fcnt == div`: step and set `fcnt` to 0.
  - Otherwise increment `fcnt`.
- In `S_STOP`, `fcnt` is held at 0.
- Step rule:
  - If x < COLS-1, then x+1.
  - Otherwise x = 0 and y advances:
    - If y < ROWS-1, then y+1.
    - Otherwise y = 0 and `out_wrap` pulses.
  - `out_step` pulses on every step.
- Hit condition: `in_pixelx[9:TILE_SHIFT]` == x and `in_pixely[9:TILE_SHIFT]` == y, compared zero-extended to equal width.

## Timing
- Reset values: position (0,0), `S_STOP`, `div` 0, `fcnt` 0, `pending` 0, `out_hit`/`out_step`/`out_wrap` 0. `out_cfg_ready` is 0 while `in_rst` is high and 1 from the first cycle after release.
- Reset mid-operation discards any pending config and any step in flight.
- Config latency: the config takes effect at the first `in_frame_start` strictly after the accept cycle. An accept in the same cycle as `in_frame_start` is applied at the next frame.
- Position outputs, `out_step` and `out_wrap` update in the cycle after `in_frame_start` and are registered.
- `out_hit` has one-cycle latency. It uses the position registered in the same cycle as the sampled pixel coordinates.
- `out_cfg_ready` falls the cycle after accept and rises the cycle after apply.

## Structure
- Package `tile_cursor_pkg` holds:
  - mode encodings (`MODE_STOP`/`RUN`/`JUMP`/`HOME`);
  - run-state enum;
  - default `COLS`/`ROWS`/`TILE_SHIFT`.
- One sub-module, `tile_pos_step`: registered x/y incrementer with load, home, and step/wrap pulse outputs. The top level holds the handshake, shadow, divider and hit compare.

## Test plan
- Reset: hold `in_rst` 3 cycles with valid high → ready 0, no accept, position (0,0), all pulses 0; ready 1 one cycle after release.
- RUN div=0 accepted before frame F0 → applied at F0 with no step. Frames F1, F2 → (1,0), (2,0). JUMP (59,0) then one frame → (0,1) with step=1 and wrap=0.
- JUMP (59,33), then RUN div=0 → next stepping frame gives (0,0), with `out_step` and `out_wrap` each high exactly one cycle.
- RUN div=2 → steps on every third frame: F3, F6, F9 after apply; `fcnt` never exceeds 2.
- Handshake:
  - A second valid while pending is not accepted and ready stays 0 until the apply cycle.
  - An accept coincident with `in_frame_start` is applied one frame later.
  - JUMP x=100, y=50 → (59,33).
- Hit: cursor (2,1).
  - Pixels (16,8) and (23,15) → `out_hit`=1 one cycle later.
  - Pixels (24,8) and (16,16) → 0.
